// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: FSM states, frame/counter widths, default timing counts
// (15.55 MHz pclk) common to the TX block and the RX register file.
package ir_pkg;

  localparam int NEC_BITS = 32;
  localparam int CNT_W    = 18;

  localparam logic [CNT_W-1:0] DEF_9MS_CNT  = 18'd139950;
  localparam logic [CNT_W-1:0] DEF_4P5_CNT  = 18'd69975;
  localparam logic [CNT_W-1:0] DEF_2P25_CNT = 18'd34988;
  localparam logic [CNT_W-1:0] DEF_560_CNT  = 18'd8708;
  localparam logic [CNT_W-1:0] DEF_1P69_CNT = 18'd26280;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    REP_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } ir_state_e;

  // Segment counter reload: a zero length still occupies one cycle.
  function automatic logic [CNT_W-1:0] seg_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  function automatic logic is_mark(input ir_state_e s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_tx_carrier.sv
// Carrier generator: free-running modulo-DIV counter, high for the first HIGH
// cycles of each period; restart forces a fresh period on the next cycle.
module ir_tx_carrier #(
  parameter int DIV  = 409,
  parameter int HIGH = 136
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic carrier
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == W'(DIV - 1))) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign carrier = (cnt_q < W'(HIGH));

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: serialises a 32-bit frame (LSB first) or a repeat code into
// mark/space segments. Define IR_TX_CARRIER_EN to modulate marks with a carrier.
module ir_nec_tx
  import ir_pkg::*;
#(
  parameter int CARRIER_DIV  = 409,
  parameter int CARRIER_HIGH = 136
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             tx_start,
  input  logic             tx_repeat,
  input  logic [31:0]      tx_data,
  input  logic             rf_ir_phase,
  input  logic [CNT_W-1:0] rf_9ms_cnt,
  input  logic [CNT_W-1:0] rf_4p5_cnt,
  input  logic [CNT_W-1:0] rf_2p25_cnt,
  input  logic [CNT_W-1:0] rf_560_cnt,
  input  logic [CNT_W-1:0] rf_1p69_cnt,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             ir_env,
  output logic             ir_out,
  output ir_state_e        dbg_state
);

  ir_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             rep_q, rep_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             env_q, env_d;
  logic             seg_end;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    done_d    = 1'b0;
    seg_end   = (cnt_q == '0);

    if (state_q != IDLE && !seg_end) cnt_d = cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        // A full-frame start takes priority over a simultaneous repeat request.
        if (tx_start || tx_repeat) begin
          state_d   = LEAD_MARK;
          cnt_d     = seg_load(rf_9ms_cnt);
          rep_d     = !tx_start;
          bit_cnt_d = '0;
          if (tx_start) shift_d = tx_data;
        end
      end
      LEAD_MARK: if (seg_end) begin
        state_d = rep_q ? REP_SPACE : LEAD_SPACE;
        cnt_d   = rep_q ? seg_load(rf_2p25_cnt) : seg_load(rf_4p5_cnt);
      end
      LEAD_SPACE: if (seg_end) begin
        state_d = BIT_MARK;
        cnt_d   = seg_load(rf_560_cnt);
      end
      REP_SPACE: if (seg_end) begin
        state_d = STOP_MARK;
        cnt_d   = seg_load(rf_560_cnt);
      end
      BIT_MARK: if (seg_end) begin
        state_d = BIT_SPACE;
        cnt_d   = shift_q[0] ? seg_load(rf_1p69_cnt) : seg_load(rf_560_cnt);
      end
      BIT_SPACE: if (seg_end) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = (bit_cnt_q == 6'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
        cnt_d     = seg_load(rf_560_cnt);
      end
      STOP_MARK: if (seg_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    env_d  = is_mark(state_d);
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rep_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      env_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      env_q     <= env_d;
    end
  end

  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign ir_env    = env_q;
  assign dbg_state = state_q;

`ifdef IR_TX_CARRIER_EN
  logic carrier;

  // Restarting on every mark entry makes each mark open with a full high phase.
  ir_tx_carrier #(
    .DIV  (CARRIER_DIV),
    .HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk     (pclk),
    .rst     (prst),
    .restart (is_mark(state_d) && !is_mark(state_q)),
    .carrier (carrier)
  );

  assign ir_out = rf_ir_phase ^ (env_q & carrier);
`else
  assign ir_out = rf_ir_phase ^ env_q;
`endif

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: cycle-accurate expected envelope queue filled by the driver,
// checked every cycle by a negedge monitor that also decodes the frame bits.
module tb_ir_nec_tx;
  import ir_pkg::*;

`ifdef IR_TX_CARRIER_EN
  localparam int C_DIV = 4, C_HIGH = 1, C560 = 8, C1P69 = 24;
`else
  localparam int C_DIV = 409, C_HIGH = 136, C560 = 3, C1P69 = 6;
`endif
  localparam int C9MS = 20, C4P5 = 10, C2P25 = 5;

  logic             pclk = 1'b0;
  logic             prst = 1'b1;
  logic             tx_start = 1'b0, tx_repeat = 1'b0;
  logic [31:0]      tx_data = '0;
  logic             rf_ir_phase = 1'b1;
  logic [CNT_W-1:0] rf_9ms_cnt = CNT_W'(C9MS), rf_4p5_cnt = CNT_W'(C4P5);
  logic [CNT_W-1:0] rf_2p25_cnt = CNT_W'(C2P25), rf_560_cnt = CNT_W'(C560);
  logic [CNT_W-1:0] rf_1p69_cnt = CNT_W'(C1P69);
  logic             tx_busy, tx_done, ir_env, ir_out;
  ir_state_e        dbg_state;

  ir_nec_tx #(.CARRIER_DIV(C_DIV), .CARRIER_HIGH(C_HIGH)) dut (
    .pclk(pclk), .prst(prst), .tx_start(tx_start), .tx_repeat(tx_repeat),
    .tx_data(tx_data), .rf_ir_phase(rf_ir_phase), .rf_9ms_cnt(rf_9ms_cnt),
    .rf_4p5_cnt(rf_4p5_cnt), .rf_2p25_cnt(rf_2p25_cnt), .rf_560_cnt(rf_560_cnt),
    .rf_1p69_cnt(rf_1p69_cnt), .tx_busy(tx_busy), .tx_done(tx_done),
    .ir_env(ir_env), .ir_out(ir_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;

  // ---------------- scoreboard state ----------------
  logic [1:0]  exp_q[$];        // per busy cycle: {env, carrier phase high}
  int          exp_len_q[$];
  logic [32:0] exp_data_q[$];   // {is_repeat, data}
  int          n_checks = 0, n_fail = 0;
  logic        mon_en = 1'b0, prev_busy = 1'b0, aborting = 1'b0;
  int          busy_len = 0, run_len = 0, nruns = 0;
  logic        run_lvl = 1'b0;
  logic [31:0] dec = '0;
  logic [1:0]  e;
  logic [32:0] txn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_out(input logic [1:0] x);
`ifdef IR_TX_CARRIER_EN
    return rf_ir_phase ^ (x[1] & x[0]);
`else
    return rf_ir_phase ^ x[1];
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_seg(input logic lvl, input int len);
    int n = (len == 0) ? 1 : len;
    for (int k = 0; k < n; k++) exp_q.push_back({lvl, lvl && ((k % C_DIV) < C_HIGH)});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Drive a request known to be accepted (DUT idle) and record its expected waveform.
  task automatic send(input logic st, input logic rp, input logic [31:0] d);
    int n0 = exp_q.size();
    tx_start = st; tx_repeat = rp; tx_data = d;
    push_seg(1'b1, int'(rf_9ms_cnt));
    if (st) begin
      push_seg(1'b0, int'(rf_4p5_cnt));
      for (int i = 0; i < 32; i++) begin
        push_seg(1'b1, int'(rf_560_cnt));
        push_seg(1'b0, d[i] ? int'(rf_1p69_cnt) : int'(rf_560_cnt));
      end
    end else begin
      push_seg(1'b0, int'(rf_2p25_cnt));
    end
    push_seg(1'b1, int'(rf_560_cnt));
    exp_len_q.push_back(exp_q.size() - n0);
    exp_data_q.push_back({!st, d});
    cycles(1);
    tx_start = 1'b0; tx_repeat = 1'b0;
  endtask

  // Request pulse expected to be ignored because the DUT is busy.
  task automatic poke(input logic st, input logic rp, input logic [31:0] d);
    tx_start = st; tx_repeat = rp; tx_data = d;
    cycles(1);
    tx_start = 1'b0; tx_repeat = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      if (!tx_busy) return;
      cycles(1);
    end
    check("wait_idle_timeout", 32'(tx_busy), 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000; i++) begin
      cycles(1);
      if (tx_done) return;
    end
    check("wait_done_timeout", 32'(tx_done), 32'd1);
  endtask

  task automatic close_run();
    if (run_len == 0) return;
    if (nruns >= 3 && nruns <= 65 && (nruns % 2) == 1)
      dec[(nruns - 3) / 2] = (run_len > (C560 + C1P69) / 2);
    nruns++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge pclk) begin
    if (mon_en) begin
      if (tx_busy) begin
        busy_len++;
        if (exp_q.size() == 0) check("busy_overrun", 32'(tx_busy), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("ir_env", 32'(ir_env), 32'(e[1]));
          check("ir_out", 32'(ir_out), 32'(exp_out(e)));
        end
        check("done_while_busy", 32'(tx_done), 32'd0);
        if (run_len != 0 && ir_env == run_lvl) run_len++;
        else begin
          close_run();
          run_lvl = ir_env;
          run_len = 1;
        end
      end else begin
        check("idle_env", 32'(ir_env), 32'd0);
        check("idle_out", 32'(ir_out), 32'(rf_ir_phase));
        if (prev_busy) begin
          if (aborting) begin
            check("abort_no_done", 32'(tx_done), 32'd0);
            exp_q.delete(); exp_len_q.delete(); exp_data_q.delete();
            aborting = 1'b0;
          end else begin
            close_run();
            check("tx_done", 32'(tx_done), 32'd1);
            if (exp_len_q.size() == 0) check("unexpected_txn", 32'd1, 32'd0);
            else check("busy_len", 32'(busy_len), 32'(exp_len_q.pop_front()));
            if (exp_data_q.size() != 0) begin
              txn = exp_data_q.pop_front();
              check("num_segments", 32'(nruns), txn[32] ? 32'd3 : 32'd67);
              if (!txn[32]) check("decoded_data", dec, txn[31:0]);
            end
          end
          busy_len = 0; nruns = 0; run_len = 0; dec = '0;
        end else if (tx_done) begin
          check("stray_done", 32'(tx_done), 32'd0);
        end
      end
      prev_busy = tx_busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    cycles(3);
    prst = 1'b0;
    cycles(1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_env", 32'(ir_env), 32'd0);
    check("reset_out", 32'(ir_out), 32'd1);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    mon_en = 1'b1;
    cycles(100);

    send(1'b1, 1'b0, 32'h00FF_A25D);
    wait_idle();
    cycles(5);

    send(1'b0, 1'b1, 32'h0);
    wait_idle();
    cycles(5);

    // start + repeat together, then ignored requests mid-frame
    send(1'b1, 1'b1, $urandom);
    cycles(40);
    poke(1'b1, 1'b0, $urandom);
    cycles(30);
    poke(1'b0, 1'b1, $urandom);
    wait_idle();
    cycles(3);

    // back-to-back: restart in the tx_done cycle
    send(1'b1, 1'b0, $urandom);
    wait_done();
    send(1'b1, 1'b0, $urandom);
    wait_idle();
    cycles(3);

    // synchronous reset mid-frame
    send(1'b1, 1'b0, $urandom);
    cycles(48);
    aborting = 1'b1;
    prst = 1'b1;
    cycles(1);
    prst = 1'b0;
    check("abort_out", 32'(ir_out), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_done", 32'(tx_done), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    cycles(4);
    send(1'b1, 1'b0, $urandom);
    wait_idle();
    cycles(3);

    // opposite pin polarity, zero-length repeat space
    rf_ir_phase = 1'b0;
    rf_2p25_cnt = '0;
    cycles(2);
    send(1'b0, 1'b1, 32'h0);
    wait_idle();
    cycles(2);
    rf_2p25_cnt = CNT_W'(C2P25);
    for (int i = 0; i < 2; i++) begin
      send(1'b1, 1'b0, $urandom);
      wait_idle();
      cycles($urandom_range(1, 6));
    end
    rf_ir_phase = 1'b1;
    cycles(10);

    check("leftover_exp", 32'(exp_q.size()), 32'd0);
    check("leftover_len", 32'(exp_len_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
